// File: rtl/sm_clock_scheduler_pkg.sv
// Shared constants and types for the PIO state-machine clock scheduler:
// default SM count, divisor field widths, CTRL field layout and the
// per-SM CLKDIV register type.
package sm_clock_scheduler_pkg;

    localparam int PIO_NUM_SM    = 4;
    localparam int CLKDIV_INT_W  = 16;
    localparam int CLKDIV_FRAC_W = 8;

    // CTRL is three NUM_SM-wide fields; each index is multiplied by NUM_SM
    // to get the LSB of that field.
    localparam int CTRL_EN_FIELD     = 0;
    localparam int CTRL_SMRST_FIELD  = 1;
    localparam int CTRL_DIVRST_FIELD = 2;

    typedef struct packed {
        logic [CLKDIV_INT_W-1:0]  int_div;
        logic [CLKDIV_FRAC_W-1:0] frac_div;
    } clkdiv_cfg_t;

    localparam clkdiv_cfg_t CLKDIV_RESET = '{int_div: CLKDIV_INT_W'(1), frac_div: '0};

    // An integer divisor of 0 stands for 2**INT_W, so the result needs one extra bit.
    function automatic logic [CLKDIV_INT_W:0] eff_divisor(input logic [CLKDIV_INT_W-1:0] int_div);
        return (int_div == '0) ? {1'b1, {CLKDIV_INT_W{1'b0}}} : {1'b0, int_div};
    endfunction

endpackage

// File: rtl/sm_clock_scheduler_if.sv
// Host-side register bus of the clock scheduler together with the
// per-SM enable, tick and restart outputs it presents to the SM array.
interface sm_clock_scheduler_if
    import sm_clock_scheduler_pkg::*;
#(
    parameter int NUM_SM = PIO_NUM_SM,
    parameter int INT_W  = CLKDIV_INT_W,
    parameter int FRAC_W = CLKDIV_FRAC_W,
    parameter int SEL_W  = (NUM_SM > 1) ? $clog2(NUM_SM) : 1
);
    logic                  ctrl_we;
    logic [3*NUM_SM-1:0]   ctrl_wdata;
    logic                  cfg_we;
    logic [SEL_W-1:0]      cfg_sel;
    logic [INT_W-1:0]      cfg_int;
    logic [FRAC_W-1:0]     cfg_frac;
    logic [INT_W-1:0]      cfg_rd_int;
    logic [FRAC_W-1:0]     cfg_rd_frac;
    logic [NUM_SM-1:0]     sm_enabled;
    logic [NUM_SM-1:0]     sm_tick;
    logic [NUM_SM-1:0]     sm_restart;

    modport master (
        output ctrl_we, ctrl_wdata, cfg_we, cfg_sel, cfg_int, cfg_frac,
        input  cfg_rd_int, cfg_rd_frac, sm_enabled, sm_tick, sm_restart
    );

    modport slave (
        input  ctrl_we, ctrl_wdata, cfg_we, cfg_sel, cfg_int, cfg_frac,
        output cfg_rd_int, cfg_rd_frac, sm_enabled, sm_tick, sm_restart
    );
endinterface

// File: rtl/sm_clock_scheduler_clkdiv.sv
// One 16.8 fractional clock divider. Emits a one-cycle tick each time its
// down-counter reaches zero while enabled; the fractional accumulator's
// carry stretches every so often an interval by one cycle.
module sm_clock_scheduler_clkdiv
    import sm_clock_scheduler_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  clkdiv_cfg_t i_cfg,
    input  logic        i_enable,
    input  logic        i_phase_restart,
    output logic        o_tick
);
    localparam int INT_W  = CLKDIV_INT_W;
    localparam int FRAC_W = CLKDIV_FRAC_W;
    localparam int CNT_W  = INT_W + 1;

    logic [CNT_W-1:0]  r_cnt;
    logic [FRAC_W-1:0] r_acc;
    logic              r_tick;
    logic [FRAC_W:0]   w_acc_sum;
    logic [CNT_W-1:0]  w_reload;

    // Reload value: effective divisor minus one, plus the fractional carry.
    // With int=0 the maximum is exactly 2**INT_W, which still fits CNT_W bits.
    always_comb begin
        w_acc_sum = {1'b0, r_acc} + {1'b0, i_cfg.frac_div};
        w_reload  = eff_divisor(i_cfg.int_div) - CNT_W'(1) + CNT_W'(w_acc_sum[FRAC_W]);
    end

    // Count down while enabled, tick and reload at zero; hold everything when disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_tick <= 1'b0;
        end else if (i_phase_restart) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_tick <= 1'b0;
        end else if (i_enable) begin
            if (r_cnt == '0) begin
                r_tick <= 1'b1;
                r_acc  <= w_acc_sum[FRAC_W-1:0];
                r_cnt  <= w_reload;
            end else begin
                r_tick <= 1'b0;
                r_cnt  <= r_cnt - CNT_W'(1);
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/sm_clock_scheduler.sv
// Clock scheduler for the PIO state machines. Holds the global CTRL
// register (enables, SM restart pulses, divider phase restarts) and the
// per-SM CLKDIV registers, and runs one fractional divider per SM.
module sm_clock_scheduler
    import sm_clock_scheduler_pkg::*;
#(
    parameter int NUM_SM = PIO_NUM_SM
)(
    input  logic                  clk,
    input  logic                  rst,
    sm_clock_scheduler_if.slave   bus
);
    logic [NUM_SM-1:0] r_enabled;
    logic [NUM_SM-1:0] r_restart;
    clkdiv_cfg_t       r_cfg [NUM_SM];
    clkdiv_cfg_t       w_rd_cfg;
    logic [NUM_SM-1:0] w_tick;
    logic [NUM_SM-1:0] w_phase_restart;

    // Phase restarts act only on the edge that writes CTRL.
    assign w_phase_restart = bus.ctrl_we ? bus.ctrl_wdata[CTRL_DIVRST_FIELD*NUM_SM +: NUM_SM]
                                         : '0;

    // CTRL: enable mask is sticky, restart field becomes a single-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_enabled <= '0;
            r_restart <= '0;
        end else if (bus.ctrl_we) begin
            r_enabled <= bus.ctrl_wdata[CTRL_EN_FIELD*NUM_SM +: NUM_SM];
            r_restart <= bus.ctrl_wdata[CTRL_SMRST_FIELD*NUM_SM +: NUM_SM];
        end else begin
            r_restart <= '0;
        end
    end

    // CLKDIV: new divisor is latched here and picked up by the divider at its next reload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SM; i++) begin
                r_cfg[i] <= CLKDIV_RESET;
            end
        end else if (bus.cfg_we && (int'(bus.cfg_sel) < NUM_SM)) begin
            r_cfg[bus.cfg_sel] <= '{int_div: bus.cfg_int, frac_div: bus.cfg_frac};
        end
    end

    // Combinational readback of the selected SM's CLKDIV.
    always_comb begin
        w_rd_cfg = '0;
        if (int'(bus.cfg_sel) < NUM_SM) begin
            w_rd_cfg = r_cfg[bus.cfg_sel];
        end
    end

    for (genvar g = 0; g < NUM_SM; g++) begin : g_div
        sm_clock_scheduler_clkdiv u_div (
            .clk             (clk),
            .rst             (rst),
            .i_cfg           (r_cfg[g]),
            .i_enable        (r_enabled[g]),
            .i_phase_restart (w_phase_restart[g]),
            .o_tick          (w_tick[g])
        );
    end

    assign bus.cfg_rd_int  = w_rd_cfg.int_div;
    assign bus.cfg_rd_frac = w_rd_cfg.frac_div;
    assign bus.sm_enabled  = r_enabled;
    assign bus.sm_tick     = w_tick;
    assign bus.sm_restart  = r_restart;

endmodule

// File: tb/tb_sm_clock_scheduler.sv
// Bench for sm_clock_scheduler: an absolute-schedule reference model plus
// directed scenarios with hand-computed tick spacings and latencies.
module tb_sm_clock_scheduler;
    import sm_clock_scheduler_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sm_clock_scheduler_if #(.NUM_SM(N)) bus ();

    sm_clock_scheduler #(.NUM_SM(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_on   = 1'b0;

    // Reference model: each SM counts its enabled edges since the last phase
    // restart (m_e) and holds the due time of its next tick in 1/256-cycle
    // units (m_due). A tick fires on the enabled edge whose index equals the
    // integer part of the due time, which then advances by int + frac/256.
    longint     m_e   [N];
    longint     m_due [N];
    int         m_int [N];
    int         m_frac[N];
    logic [N-1:0] m_en, m_tick, m_rs;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_e[i]    <= 0;
                m_due[i]  <= 0;
                m_int[i]  <= 1;
                m_frac[i] <= 0;
            end
            m_en   <= '0;
            m_tick <= '0;
            m_rs   <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (m_en[i] && ((m_due[i] >> 8) == m_e[i])) begin
                    m_tick[i] <= 1'b1;
                    m_due[i]  <= m_due[i] + 256 * longint'((m_int[i] == 0) ? 65536 : m_int[i])
                                 + longint'(m_frac[i]);
                end else begin
                    m_tick[i] <= 1'b0;
                end
                if (m_en[i]) m_e[i] <= m_e[i] + 1;
            end
            m_rs <= bus.ctrl_we ? bus.ctrl_wdata[N +: N] : '0;
            if (bus.ctrl_we) begin
                m_en <= bus.ctrl_wdata[0 +: N];
                for (int i = 0; i < N; i++) begin
                    if (bus.ctrl_wdata[2*N + i]) begin
                        m_e[i]    <= 0;
                        m_due[i]  <= 0;
                        m_tick[i] <= 1'b0;
                    end
                end
            end
            if (bus.cfg_we) begin
                m_int[bus.cfg_sel]  <= int'(bus.cfg_int);
                m_frac[bus.cfg_sel] <= int'(bus.cfg_frac);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic ctrl_wr(input logic [N-1:0] en, input logic [N-1:0] rs, input logic [N-1:0] cr);
        @(posedge clk); #1;
        bus.ctrl_we    = 1'b1;
        bus.ctrl_wdata = {cr, rs, en};
        @(posedge clk); #1;
        bus.ctrl_we    = 1'b0;
    endtask

    task automatic cfg_wr(input int sel, input int iv, input int fv);
        @(posedge clk); #1;
        bus.cfg_we   = 1'b1;
        bus.cfg_sel  = 2'(sel);
        bus.cfg_int  = 16'(iv);
        bus.cfg_frac = 8'(fv);
        @(posedge clk); #1;
        bus.cfg_we   = 1'b0;
    endtask

    task automatic both_wr(input logic [N-1:0] en, input logic [N-1:0] cr,
                           input int sel, input int iv, input int fv);
        @(posedge clk); #1;
        bus.ctrl_we    = 1'b1;
        bus.ctrl_wdata = {cr, {N{1'b0}}, en};
        bus.cfg_we     = 1'b1;
        bus.cfg_sel    = 2'(sel);
        bus.cfg_int    = 16'(iv);
        bus.cfg_frac   = 8'(fv);
        @(posedge clk); #1;
        bus.ctrl_we    = 1'b0;
        bus.cfg_we     = 1'b0;
    endtask

    // Number of falling edges until sm_tick[sm] is next seen high (bounded).
    task automatic next_tick(input int sm, input int limit, output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.sm_tick[sm] !== 1'b1 && k < limit);
    endtask

    initial begin
        int k;
        int cnt;
        logic [5:0] pat;

        bus.ctrl_we = 1'b0; bus.ctrl_wdata = '0;
        bus.cfg_we  = 1'b0; bus.cfg_sel = '0; bus.cfg_int = '0; bus.cfg_frac = '0;

        fork
            forever begin
                @(negedge clk);
                if (mon_on) begin
                    chk("model_tick",    32'(bus.sm_tick),    32'(m_tick));
                    chk("model_enabled", 32'(bus.sm_enabled), 32'(m_en));
                    chk("model_restart", 32'(bus.sm_restart), 32'(m_rs));
                    chk("model_rd_int",  32'(bus.cfg_rd_int),  32'(m_int[bus.cfg_sel]));
                    chk("model_rd_frac", 32'(bus.cfg_rd_frac), 32'(m_frac[bus.cfg_sel]));
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mon_on = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_enabled", 32'(bus.sm_enabled), 32'h0);
        chk("rst_tick",    32'(bus.sm_tick),    32'h0);
        chk("rst_restart", 32'(bus.sm_restart), 32'h0);
        chk("rst_rd_int",  32'(bus.cfg_rd_int), 32'd1);
        chk("rst_rd_frac", 32'(bus.cfg_rd_frac), 32'd0);

        // Default divider ticks every cycle from the second edge after enable
        ctrl_wr(4'b0001, 4'b0000, 4'b0000);
        @(negedge clk);
        chk("t1_first_edge", 32'(bus.sm_tick), 32'h0);
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            chk("t1_every_cycle", 32'(bus.sm_tick), 32'h1);
        end

        // int=3: pattern 1,0,0 and 100 ticks in 300 cycles
        cfg_wr(1, 3, 0);
        ctrl_wr(4'b0011, 4'b0000, 4'b0000);
        next_tick(1, 10, k);
        chk("t2_first_latency", 32'(k), 32'd2);
        pat[5] = bus.sm_tick[1];
        for (int j = 4; j >= 0; j--) begin
            @(negedge clk);
            pat[j] = bus.sm_tick[1];
        end
        chk("t2_pattern", 32'(pat), 32'b100100);
        cnt = 0;
        for (int j = 0; j < 300; j++) begin
            @(negedge clk);
            cnt += int'(bus.sm_tick[1]);
        end
        chk("t2_count300", 32'(cnt), 32'd100);

        // int=1 frac=128: 1,1,0 repeating -> 200 ticks in 300 cycles
        cfg_wr(2, 1, 128);
        ctrl_wr(4'b0111, 4'b0000, 4'b0000);
        next_tick(2, 10, k);
        chk("t3_first_latency", 32'(k), 32'd2);
        cnt = 0;
        for (int j = 0; j < 300; j++) begin
            cnt += int'(bus.sm_tick[2]);
            @(negedge clk);
        end
        chk("t3_count300", 32'(cnt), 32'd200);

        // int=0 frac=0: ticks 65536 cycles apart
        cfg_wr(2, 0, 0);
        ctrl_wr(4'b0100, 4'b0000, 4'b0100);
        next_tick(2, 10, k);
        chk("t3_restart_latency", 32'(k), 32'd2);
        next_tick(2, 70000, k);
        chk("t3_int0_spacing", 32'(k), 32'd65536);

        // int=5: stall preserves phase
        cfg_wr(0, 5, 0);
        ctrl_wr(4'b0001, 4'b0000, 4'b0001);
        next_tick(0, 10, k);
        chk("t4_first_latency", 32'(k), 32'd2);
        ctrl_wr(4'b0000, 4'b0000, 4'b0000);
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            chk("t4_stalled", 32'(bus.sm_tick), 32'h0);
        end
        ctrl_wr(4'b0001, 4'b0000, 4'b0000);
        next_tick(0, 20, k);
        chk("t4_resume_latency", 32'(k), 32'd4);
        next_tick(0, 20, k);
        chk("t4_spacing5", 32'(k), 32'd5);

        // Phase restart and new divisor on the same edge
        both_wr(4'b0001, 4'b0001, 0, 7, 0);
        next_tick(0, 10, k);
        chk("t5_restart_latency", 32'(k), 32'd2);
        next_tick(0, 20, k);
        chk("t5_spacing7_a", 32'(k), 32'd7);
        next_tick(0, 20, k);
        chk("t5_spacing7_b", 32'(k), 32'd7);

        // SM restart pulse lasts one cycle and leaves enables alone
        ctrl_wr(4'b0001, 4'b1010, 4'b0000);
        @(negedge clk);
        chk("t6_pulse",       32'(bus.sm_restart), 32'b1010);
        chk("t6_enabled",     32'(bus.sm_enabled), 32'b0001);
        @(negedge clk);
        chk("t6_pulse_end",   32'(bus.sm_restart), 32'b0000);
        chk("t6_enabled_end", 32'(bus.sm_enabled), 32'b0001);

        // Asynchronous reset mid-count
        cfg_wr(1, 3, 0);
        ctrl_wr(4'b0011, 4'b0000, 4'b0000);
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t7_enabled", 32'(bus.sm_enabled), 32'h0);
        chk("t7_tick",    32'(bus.sm_tick),    32'h0);
        chk("t7_restart", 32'(bus.sm_restart), 32'h0);
        chk("t7_rd_int_sm1",  32'(bus.cfg_rd_int),  32'd1);
        chk("t7_rd_frac_sm1", 32'(bus.cfg_rd_frac), 32'd0);
        bus.cfg_sel = 2'd0;
        #1;
        chk("t7_rd_int_sm0",  32'(bus.cfg_rd_int),  32'd1);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t7_after_tick", 32'(bus.sm_tick), 32'h0);

        mon_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
